// File: rtl/inst_buf_pkg.sv
// Shared types and constants for the instruction page buffer.
// Fill-state encoding, the NOP returned when no valid instruction is held, and page/index widths.
package inst_buf_pkg;

    localparam int PAGE_NUM_W = 20;
    localparam int WORD_IDX_W = 10;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } fill_state_e;

endpackage

// File: rtl/inst_page_ram.sv
// Simple dual-port page RAM: one write port, one read port with a registered, enable-gated output.
// The output register holds its value while re_i is low, so it doubles as the fetch output register.
module inst_page_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_page_buffer.sv
// Instruction page buffer: captures a 4 KiB AXI page fill into page RAM and serves fetches by PC.
// Define INST_BUF_EARLY_RESTART_EN to serve already-written words of the page that is still filling.
//
//   state    | meaning
//   ST_IDLE  | no fill running; RAM holds LOADED_PAGE when LOADED
//   ST_FILL  | writing beats of the pending page, checking burst framing
//   ST_DRAIN | fill aborted; remaining beats are counted out without writing
module inst_page_buffer
    import inst_buf_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int PAGE_WORDS  = 1024,
    parameter int BURST_BEATS = 32
) (
    input  logic                  CCLK,
    input  logic                  CRST,
    input  logic                  FILL_START,
    input  logic [PAGE_NUM_W-1:0] FILL_PAGE,
    input  logic                  R_VALID,
    input  logic [DATA_WIDTH-1:0] R_DATA,
    input  logic [1:0]            R_RESP,
    input  logic                  R_LAST,
    output logic                  FILL_BUSY,
    output logic                  FILL_DONE,
    output logic                  FILL_ERR,
    output logic                  LOADED,
    output logic [PAGE_NUM_W-1:0] LOADED_PAGE,
    input  logic                  STALL,
    input  logic                  PC_VALID,
    input  logic [31:0]           PC,
    output logic                  MEM_WAIT,
    output logic                  INST_VALID,
    output logic [DATA_WIDTH-1:0] INST
);

    localparam int                    BEAT_W    = $clog2(BURST_BEATS);
    localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(BURST_BEATS - 1);
    localparam logic [WORD_IDX_W-1:0] WPTR_LAST = WORD_IDX_W'(PAGE_WORDS - 1);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("inst_page_buffer: only DATA_WIDTH = 32 is supported");
    end
    if (PAGE_WORDS != (1 << WORD_IDX_W)) begin : g_bad_page_words
        $error("inst_page_buffer: PAGE_WORDS must match the 4 KiB page index width");
    end
    if ((PAGE_WORDS % BURST_BEATS) != 0) begin : g_bad_burst
        $error("inst_page_buffer: PAGE_WORDS must be a multiple of BURST_BEATS");
    end

    fill_state_e             state_q, state_d;
    logic [PAGE_NUM_W-1:0]   pend_page_q, pend_page_d;
    logic [WORD_IDX_W-1:0]   wptr_q, wptr_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic                    loaded_q, loaded_d;
    logic [PAGE_NUM_W-1:0]   loaded_page_q, loaded_page_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    beat_err;
    logic                    ram_we;

    // A burst is well framed only when R_LAST coincides exactly with the final beat slot.
    always_comb begin
        beat_err = (R_RESP != 2'b00) || (R_LAST != (beat_q == BEAT_LAST));
        ram_we   = R_VALID && (state_q == ST_FILL) && !beat_err;
    end

    always_comb begin
        state_d       = state_q;
        pend_page_d   = pend_page_q;
        wptr_d        = wptr_q;
        beat_d        = beat_q;
        loaded_d      = loaded_q;
        loaded_page_d = loaded_page_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (FILL_START) begin
                    state_d     = ST_FILL;
                    pend_page_d = FILL_PAGE;
                    wptr_d      = '0;
                    beat_d      = '0;
                    loaded_d    = 1'b0;
                end
            end
            ST_FILL: begin
                if (R_VALID) begin
                    wptr_d = wptr_q + 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (beat_err) begin
                        state_d = ST_DRAIN;
                        err_d   = 1'b1;
                    end else if (R_LAST && (wptr_q == WPTR_LAST)) begin
                        state_d       = ST_IDLE;
                        loaded_d      = 1'b1;
                        loaded_page_d = pend_page_q;
                        done_d        = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (R_VALID) begin
                    wptr_d = wptr_q + 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (R_LAST && (wptr_q == WPTR_LAST)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CCLK) begin
        if (!CRST) begin
            state_q       <= ST_IDLE;
            pend_page_q   <= '0;
            wptr_q        <= '0;
            beat_q        <= '0;
            loaded_q      <= 1'b0;
            loaded_page_q <= '1;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_page_q   <= pend_page_d;
            wptr_q        <= wptr_d;
            beat_q        <= beat_d;
            loaded_q      <= loaded_d;
            loaded_page_q <= loaded_page_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign FILL_BUSY   = (state_q != ST_IDLE);
    assign FILL_DONE   = done_q;
    assign FILL_ERR    = err_q;
    assign LOADED      = loaded_q;
    assign LOADED_PAGE = loaded_page_q;

    logic [PAGE_NUM_W-1:0] pc_page;
    logic [WORD_IDX_W-1:0] pc_idx;
    logic [1:0]            unused_pc_lsb;

    assign pc_page       = PC[31:32-PAGE_NUM_W];
    assign pc_idx        = PC[WORD_IDX_W+1:2];
    assign unused_pc_lsb = PC[1:0];

    logic early_hit;
    logic fwd_hit;
    logic hit;

`ifdef INST_BUF_EARLY_RESTART_EN
    logic fill_page_match;

    // Words below wptr are already in RAM; the word at wptr is being written this very cycle.
    assign fill_page_match = (state_q == ST_FILL) && (pend_page_q == pc_page);
    assign early_hit       = fill_page_match && (pc_idx < wptr_q);
    assign fwd_hit         = fill_page_match && ram_we && (pc_idx == wptr_q);
`else
    assign early_hit = 1'b0;
    assign fwd_hit   = 1'b0;
`endif

    assign hit      = (loaded_q && (loaded_page_q == pc_page)) || early_hit || fwd_hit;
    assign MEM_WAIT = PC_VALID && !hit;

    logic [DATA_WIDTH-1:0] ram_rdata;

    inst_page_ram #(
        .DEPTH (PAGE_WORDS),
        .WIDTH (DATA_WIDTH),
        .AW    (WORD_IDX_W)
    ) u_ram (
        .clk_i   (CCLK),
        .we_i    (ram_we),
        .waddr_i (wptr_q),
        .wdata_i (R_DATA),
        .re_i    (!STALL),
        .raddr_i (pc_idx),
        .rdata_o (ram_rdata)
    );

    logic inst_valid_q;

    always_ff @(posedge CCLK) begin
        if (!CRST) begin
            inst_valid_q <= 1'b0;
        end else if (!STALL) begin
            inst_valid_q <= PC_VALID && hit;
        end
    end

    assign INST_VALID = inst_valid_q;

`ifdef INST_BUF_EARLY_RESTART_EN
    logic                  fwd_sel_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    // The RAM returns stale data on a same-address read/write, so the beat is captured beside it.
    always_ff @(posedge CCLK) begin
        if (!CRST) begin
            fwd_sel_q  <= 1'b0;
            fwd_data_q <= '0;
        end else if (!STALL) begin
            fwd_sel_q  <= PC_VALID && fwd_hit;
            fwd_data_q <= R_DATA;
        end
    end

    always_comb begin
        INST = DATA_WIDTH'(NOP_INST);
        if (inst_valid_q) begin
            INST = fwd_sel_q ? fwd_data_q : ram_rdata;
        end
    end
`else
    always_comb begin
        INST = DATA_WIDTH'(NOP_INST);
        if (inst_valid_q) begin
            INST = ram_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_inst_page_buffer.sv
// Directed bench for inst_page_buffer: reset, full/aborted/malformed fills, table-driven reads and stall.
module tb_inst_page_buffer;

    logic        CCLK;
    logic        CRST;
    logic        FILL_START;
    logic [19:0] FILL_PAGE;
    logic        R_VALID;
    logic [31:0] R_DATA;
    logic [1:0]  R_RESP;
    logic        R_LAST;
    logic        FILL_BUSY;
    logic        FILL_DONE;
    logic        FILL_ERR;
    logic        LOADED;
    logic [19:0] LOADED_PAGE;
    logic        STALL;
    logic        PC_VALID;
    logic [31:0] PC;
    logic        MEM_WAIT;
    logic        INST_VALID;
    logic [31:0] INST;

    inst_page_buffer dut (
        .CCLK        (CCLK),
        .CRST        (CRST),
        .FILL_START  (FILL_START),
        .FILL_PAGE   (FILL_PAGE),
        .R_VALID     (R_VALID),
        .R_DATA      (R_DATA),
        .R_RESP      (R_RESP),
        .R_LAST      (R_LAST),
        .FILL_BUSY   (FILL_BUSY),
        .FILL_DONE   (FILL_DONE),
        .FILL_ERR    (FILL_ERR),
        .LOADED      (LOADED),
        .LOADED_PAGE (LOADED_PAGE),
        .STALL       (STALL),
        .PC_VALID    (PC_VALID),
        .PC          (PC),
        .MEM_WAIT    (MEM_WAIT),
        .INST_VALID  (INST_VALID),
        .INST        (INST)
    );

    initial CCLK = 1'b0;
    always #5 CCLK = ~CCLK;

`ifdef INST_BUF_EARLY_RESTART_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        stall;
        logic        exp_wait;
        logic        exp_valid;
        logic        chk_inst;
        logic [31:0] exp_inst;
    } rd_vec_t;

    rd_vec_t vecs [12];

    int n_pass  = 0;
    int n_total = 0;

    int f_done, f_done_at, f_err, f_err_at, f_busy_drop;
    int f_loaded_start, f_wait_start, f_loaded_last, f_wait_final, f_wait_after;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CCLK);
        #1;
    endtask

    function automatic logic [31:0] beat_data(input int mode, input int i);
        case (mode)
            0:       return 32'(i);
            1:       return 32'(i * 3 + 7);
            default: return 32'hBAD0_0000 | 32'(i);
        endcase
    endfunction

    task automatic sample_pulses(input int i);
        if (FILL_DONE) begin
            f_done++;
            f_done_at = i;
        end
        if (FILL_ERR) begin
            f_err++;
            if (f_err_at < 0) f_err_at = i;
        end
        if (!FILL_BUSY && f_busy_drop < 0) f_busy_drop = i;
    endtask

    // mode 1 also inserts an idle cycle after every 7th beat and a stray FILL_START at beat 500.
    task automatic run_fill(input logic [19:0] page, input int mode, input int n_beats,
                            input int err_beat, input int short_last, input int no_last);
        f_done = 0; f_done_at = -1; f_err = 0; f_err_at = -1; f_busy_drop = -1;
        f_loaded_last = -1; f_wait_final = -1; f_wait_after = -1;
        FILL_START = 1'b1;
        FILL_PAGE  = page;
        tick();
        FILL_START = 1'b0;
        f_loaded_start = int'(LOADED);
        PC_VALID = 1'b1;
        PC = {page, 12'h000};
        #1;
        f_wait_start = int'(MEM_WAIT);
        PC_VALID = 1'b0;
        for (int i = 0; i < n_beats; i++) begin
            R_VALID = 1'b1;
            R_DATA  = beat_data(mode, i);
            R_RESP  = (i == err_beat) ? 2'd2 : 2'd0;
            R_LAST  = (i == short_last) || (((i % 32) == 31) && (i != no_last));
            if (mode == 1 && i == 500) begin
                FILL_START = 1'b1;
                FILL_PAGE  = 20'h55555;
            end
            if (i == n_beats - 1) begin
                PC_VALID = 1'b1;
                PC = {page, 12'hFFC};
                #1;
                f_wait_final = int'(MEM_WAIT);
            end
`ifdef INST_BUF_EARLY_RESTART_EN
            if (mode == 1 && i == 5) begin
                PC_VALID = 1'b1;
                PC = {page, 12'h018};
                #1;
                chk("er_word6_wait", 32'(MEM_WAIT), 32'd1);
                PC = {page, 12'h014};
                #1;
                chk("er_word5_wait", 32'(MEM_WAIT), 32'd0);
            end
`endif
            tick();
            FILL_START = 1'b0;
            R_VALID = 1'b0;
            R_LAST  = 1'b0;
            R_RESP  = 2'd0;
`ifdef INST_BUF_EARLY_RESTART_EN
            if (mode == 1 && i == 5) begin
                chk("er_word5_valid", 32'(INST_VALID), 32'd1);
                chk("er_word5_inst", INST, 32'd22);
                PC_VALID = 1'b0;
            end
`endif
            sample_pulses(i);
            if (i == n_beats - 1) begin
                f_loaded_last = int'(LOADED);
                f_wait_after  = int'(MEM_WAIT);
                PC_VALID = 1'b0;
            end
            if (mode == 1 && (i % 7) == 6) begin
                tick();
                sample_pulses(i);
            end
        end
    endtask

    task automatic read_chk(input string name, input logic [31:0] pc, input logic [31:0] exp_inst);
        PC_VALID = 1'b1;
        PC = pc;
        #1;
        chk({name, "_wait"}, 32'(MEM_WAIT), 32'd0);
        tick();
        chk({name, "_valid"}, 32'(INST_VALID), 32'd1);
        chk({name, "_inst"}, INST, exp_inst);
        PC_VALID = 1'b0;
    endtask

    initial begin
        //           pv    pc            stall wait  valid chk   inst
        vecs[0]  = '{1'b1, 32'h2000_0FFC, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_03FF};
        vecs[1]  = '{1'b1, 32'h2000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[2]  = '{1'b1, 32'h2000_0004, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0001};
        vecs[3]  = '{1'b1, 32'h2000_0803, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200};
        vecs[4]  = '{1'b1, 32'h2000_1000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000};
        vecs[5]  = '{1'b0, 32'h2000_0008, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
        vecs[6]  = '{1'b1, 32'h2000_0010, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0004};
        vecs[7]  = '{1'b1, 32'h2000_0020, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0004};
        vecs[8]  = '{1'b1, 32'h3000_0000, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0004};
        vecs[9]  = '{1'b0, 32'h2000_0040, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0004};
        vecs[10] = '{1'b1, 32'h2000_0040, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0010};
        vecs[11] = '{1'b1, 32'h2000_0ABC, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_02AF};

        CRST = 1'b0; FILL_START = 1'b0; FILL_PAGE = '0; R_VALID = 1'b0; R_DATA = '0;
        R_RESP = 2'd0; R_LAST = 1'b0; STALL = 1'b0; PC_VALID = 1'b0; PC = '0;
        repeat (3) tick();
        chk("rst_inst_valid", 32'(INST_VALID), 32'd0);
        chk("rst_inst", INST, 32'h0000_0013);
        chk("rst_loaded", 32'(LOADED), 32'd0);
        chk("rst_loaded_page", 32'(LOADED_PAGE), 32'h000F_FFFF);
        chk("rst_busy", 32'(FILL_BUSY), 32'd0);
        chk("rst_done", 32'(FILL_DONE), 32'd0);
        chk("rst_err", 32'(FILL_ERR), 32'd0);
        CRST = 1'b1;

        PC_VALID = 1'b1;
        PC = 32'h2000_0000;
        #1;
        chk("miss_wait", 32'(MEM_WAIT), 32'd1);
        tick();
        chk("miss_valid", 32'(INST_VALID), 32'd0);
        chk("miss_inst", INST, 32'h0000_0013);
        PC_VALID = 1'b0;

        run_fill(20'h20000, 0, 1024, -1, -1, -1);
        chk("fa_done_cnt", 32'(f_done), 32'd1);
        chk("fa_done_at", 32'(f_done_at), 32'd1023);
        chk("fa_err_cnt", 32'(f_err), 32'd0);
        chk("fa_busy_drop", 32'(f_busy_drop), 32'd1023);
        chk("fa_loaded_last", 32'(f_loaded_last), 32'd1);
        chk("fa_loaded_page", 32'(LOADED_PAGE), 32'h0002_0000);
        chk("fa_wait_final", 32'(f_wait_final), EARLY_EN ? 32'd0 : 32'd1);
        chk("fa_wait_after", 32'(f_wait_after), 32'd0);

        for (int k = 0; k < 12; k++) begin
            PC_VALID = vecs[k].pv;
            PC       = vecs[k].pc;
            STALL    = vecs[k].stall;
            #1;
            chk($sformatf("rd%0d_wait", k), 32'(MEM_WAIT), 32'(vecs[k].exp_wait));
            tick();
            chk($sformatf("rd%0d_valid", k), 32'(INST_VALID), 32'(vecs[k].exp_valid));
            if (vecs[k].chk_inst) begin
                chk($sformatf("rd%0d_inst", k), INST, vecs[k].exp_inst);
            end
        end
        PC_VALID = 1'b0;
        STALL    = 1'b0;

        run_fill(20'h20000, 2, 1024, 100, -1, -1);
        chk("fe_loaded_start", 32'(f_loaded_start), 32'd0);
        chk("fe_wait_start", 32'(f_wait_start), 32'd1);
        chk("fe_err_cnt", 32'(f_err), 32'd1);
        chk("fe_err_at", 32'(f_err_at), 32'd100);
        chk("fe_done_cnt", 32'(f_done), 32'd0);
        chk("fe_busy_drop", 32'(f_busy_drop), 32'd1023);
        chk("fe_loaded", 32'(LOADED), 32'd0);
        PC_VALID = 1'b1;
        PC = 32'h2000_0FFC;
        #1;
        chk("fe_wait_after", 32'(MEM_WAIT), 32'd1);
        PC_VALID = 1'b0;

        run_fill(20'h12345, 2, 40, -1, 15, -1);
        chk("fs_err_cnt", 32'(f_err), 32'd1);
        chk("fs_err_at", 32'(f_err_at), 32'd15);
        chk("fs_busy", 32'(FILL_BUSY), 32'd1);

        CRST = 1'b0;
        tick();
        chk("rm_busy", 32'(FILL_BUSY), 32'd0);
        chk("rm_loaded", 32'(LOADED), 32'd0);
        chk("rm_loaded_page", 32'(LOADED_PAGE), 32'h000F_FFFF);
        chk("rm_inst_valid", 32'(INST_VALID), 32'd0);
        chk("rm_inst", INST, 32'h0000_0013);
        CRST = 1'b1;

        run_fill(20'h12345, 2, 40, -1, -1, 31);
        chk("fn_err_cnt", 32'(f_err), 32'd1);
        chk("fn_err_at", 32'(f_err_at), 32'd31);
        CRST = 1'b0;
        tick();
        CRST = 1'b1;

        run_fill(20'h12345, 1, 1024, -1, -1, -1);
        chk("fb_done_cnt", 32'(f_done), 32'd1);
        chk("fb_done_at", 32'(f_done_at), 32'd1023);
        chk("fb_err_cnt", 32'(f_err), 32'd0);
        chk("fb_busy_drop", 32'(f_busy_drop), 32'd1023);
        chk("fb_loaded_page", 32'(LOADED_PAGE), 32'h0001_2345);
        chk("fb_wait_final", 32'(f_wait_final), EARLY_EN ? 32'd0 : 32'd1);

        read_chk("fb_rd_last", 32'h1234_5FFC, 32'h0000_0C04);
        read_chk("fb_rd_first", 32'h1234_5000, 32'h0000_0007);
        read_chk("fb_rd_100", 32'h1234_5190, 32'h0000_0133);
        PC_VALID = 1'b1;
        PC = 32'h2000_0000;
        #1;
        chk("fb_old_page_wait", 32'(MEM_WAIT), 32'd1);
        tick();
        chk("fb_old_page_valid", 32'(INST_VALID), 32'd0);
        PC_VALID = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
